rib_arb: RTL and testbench
==========================

Name: rib_arb

Overview:
- Fixed-priority, transaction-locking arbiter that shares the single system bus slave port between up to NUM_M bus masters: JTAG debug, EXU load/store, CLINT and IFU fetch.
- Grants one master at a time and holds the grant until the slave acknowledges or a timeout fires.
- Drives the bus-hold request consumed by the pipeline control logic as its bus-module stall input, which freezes the PC.

Parameters:
- NUM_M, 4, number of masters; index 0 = highest priority; index NUM_M-1 = IFU (lowest).
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 255, cycles in ACTIVE without s_ack_i before the transaction is aborted; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- m_req_i  in  NUM_M  per-master request; held high until that master's m_rvalid_o
- m_addr_i  in  NUM_M*AW  per-master address, packed, master i at [i*AW +: AW]
- m_we_i  in  NUM_M  per-master write enable
- m_wdata_i  in  NUM_M*DW  per-master write data, packed
- m_gnt_o  out  NUM_M  one-hot current owner
- m_rvalid_o  out  NUM_M  one-cycle completion pulse to the owner
- m_rdata_o  out  DW  read data, shared, valid with m_rvalid_o
- m_err_o  out  1  timeout flag, valid with m_rvalid_o
- s_req_o  out  1  slave request
- s_addr_o  out  AW  slave address
- s_we_o  out  1  slave write enable
- s_wdata_o  out  DW  slave write data
- s_rdata_i  in  DW  slave read data, valid with s_ack_i
- s_ack_i  in  1  slave completion, single-cycle
- hold_flag_o  out  1  bus stall request to pipeline control

Behaviour:
- Reset: state=IDLE, owner=0, timeout count=0, all outputs 0; takes effect asynchronously.
- Reset mid-transaction: s_req_o drops immediately, no m_rvalid_o is issued, and the in-flight transaction is lost.
- States: IDLE, ACTIVE, RESP.
- IDLE:
  - If |m_req_i: owner <= lowest set index; latch that master's addr/we/wdata into internal registers; go to ACTIVE at the next edge.
  - Otherwise remain in IDLE.
- ACTIVE:
  - s_req_o=1; s_addr_o/s_we_o/s_wdata_o come from the latched registers, never directly from m_* inputs.
  - m_gnt_o = onehot(owner).
  - Count increments each cycle.
  - On s_ack_i: latch s_rdata_i, err=0, go to RESP.
  - Else if count == TIMEOUT-1: rdata=0, err=1, go to RESP.
  - s_ack_i takes priority over timeout in the same cycle.
- RESP:
  - m_rvalid_o[owner]=1, m_rdata_o=latched data, m_err_o=latched err, all for exactly one cycle.
  - s_req_o=0; m_gnt_o still onehot(owner).
  - Go to IDLE; count cleared.
- Outside RESP, m_rvalid_o=0, m_rdata_o=0, m_err_o=0.
- Latency: req seen in IDLE at cycle 0 -> s_req_o at cycle 1 -> ack at cycle k -> m_rvalid_o at cycle k+1 -> next arbitration at cycle k+2. Back-to-back throughput is one transaction per 3+ cycles.
- No preemption: a higher-priority request arriving during ACTIVE/RESP waits for IDLE.
- If the owner drops m_req_i early, the transaction still completes; the response is discarded by the master.
- Starvation of low-priority masters under continuous high-priority requests is accepted by design.
- hold_flag_o (combinational) = (state!=IDLE && owner!=NUM_M-1) || (|m_req_i[NUM_M-2:0]). IFU-only traffic never raises the hold.
- s_ack_i in IDLE or RESP is ignored.

Decomposition:
- Shared package/header: ARB_IDLE/ARB_ACTIVE/ARB_RESP state encodings (2-bit), master index constants (JTAG=0, EXU=1, CLINT=2, IFU=3), timeout counter width = clog2(TIMEOUT+1).
- One natural sub-module: rib_prio_enc, a parameterized lowest-index-first priority encoder producing the owner index and a valid flag.
- Mux, latches and FSM stay in rib_arb.

Test Plan:
- Reset, then m_req_i=4'b1000, IFU addr 0x0000_0100, slave acks at cycle 3 with rdata 0xDEADBEEF -> s_req_o cycles 1-3, m_rvalid_o=4'b1000 at cycle 4 with rdata 0xDEADBEEF, err=0, hold_flag_o=0 throughout.
- m_req_i=4'b1010 at cycle 0 -> EXU (bit1) granted first, hold_flag_o=1 from cycle 0; IFU is granted only after EXU's RESP.
- EXU write, addr 0x1000_0004, wdata 0x55AA55AA, we=1 -> s_addr_o/s_wdata_o/s_we_o match; changing m_wdata_i mid-ACTIVE does not alter s_wdata_o.
- TIMEOUT=4, slave never acks -> s_req_o high for exactly 4 cycles, then m_rvalid_o pulse with m_err_o=1, m_rdata_o=0; arbiter returns to IDLE.
- s_ack_i coincident with the timeout cycle -> err=0, slave data returned.
- Assert rst during ACTIVE -> s_req_o, m_gnt_o and hold_flag_o go 0 before the next clk edge; no m_rvalid_o; after release with requests pending, normal arbitration resumes.

Source files
------------

// File: rtl/rib_arb_pkg.sv
// Shared types and constants for the RIB system-bus arbiter.
// Holds FSM state encodings, master index assignments and width helpers.
package rib_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACTIVE = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  localparam int M_JTAG  = 0;
  localparam int M_EXU   = 1;
  localparam int M_CLINT = 2;
  localparam int M_IFU   = 3;

  // The counter must be able to hold TIMEOUT itself, hence the +1.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rib_prio_enc.sv
// Lowest-index-first priority encoder: index 0 always wins.
// valid_o is high whenever any request bit is set.
module rib_prio_enc #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req_i,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  // Scan from the top down so the last hit is the lowest set index.
  always_comb begin
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) idx_o = IW'(i);
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/rib_arb.sv
// Fixed-priority, transaction-locking arbiter sharing the single bus slave
// between JTAG, EXU, CLINT and IFU, with a pipeline hold request output.
module rib_arb
  import rib_arb_pkg::*;
#(
  parameter int NUM_M   = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_M-1:0]    m_req_i,
  input  logic [NUM_M*AW-1:0] m_addr_i,
  input  logic [NUM_M-1:0]    m_we_i,
  input  logic [NUM_M*DW-1:0] m_wdata_i,
  output logic [NUM_M-1:0]    m_gnt_o,
  output logic [NUM_M-1:0]    m_rvalid_o,
  output logic [DW-1:0]       m_rdata_o,
  output logic                m_err_o,
  output logic                s_req_o,
  output logic [AW-1:0]       s_addr_o,
  output logic                s_we_o,
  output logic [DW-1:0]       s_wdata_o,
  input  logic [DW-1:0]       s_rdata_i,
  input  logic                s_ack_i,
  output logic                hold_flag_o
);

  localparam int OW = idx_width(NUM_M);
  localparam int CW = cnt_width(TIMEOUT);

  arb_state_e    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          err_q, err_d;

  logic [OW-1:0] enc_idx;
  logic          enc_valid;
  logic [AW-1:0] sel_addr;
  logic          sel_we;
  logic [DW-1:0] sel_wdata;
  logic [NUM_M-1:0] owner_onehot;

  rib_prio_enc #(
    .N  (NUM_M),
    .IW (OW)
  ) u_prio_enc (
    .req_i   (m_req_i),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (enc_idx == OW'(i)) begin
        sel_addr  = m_addr_i[i*AW +: AW];
        sel_we    = m_we_i[i];
        sel_wdata = m_wdata_i[i*DW +: DW];
      end
    end
  end

  // The winning master's command is captured once in IDLE so the slave sees
  // a stable transaction even if the master changes its inputs afterwards.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ARB_IDLE: begin
        cnt_d = '0;
        if (enc_valid) begin
          owner_d = enc_idx;
          addr_d  = sel_addr;
          we_d    = sel_we;
          wdata_d = sel_wdata;
          state_d = ARB_ACTIVE;
        end
      end
      ARB_ACTIVE: begin
        cnt_d = cnt_q + CW'(1);
        if (s_ack_i) begin
          rdata_d = s_rdata_i;
          err_d   = 1'b0;
          state_d = ARB_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ARB_RESP;
        end
      end
      ARB_RESP: begin
        cnt_d   = '0;
        state_d = ARB_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      owner_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    owner_onehot          = '0;
    owner_onehot[owner_q] = 1'b1;
  end

  always_comb begin
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_rdata_o  = '0;
    m_err_o    = 1'b0;
    s_req_o    = 1'b0;
    s_addr_o   = '0;
    s_we_o     = 1'b0;
    s_wdata_o  = '0;
    case (state_q)
      ARB_ACTIVE: begin
        m_gnt_o   = owner_onehot;
        s_req_o   = 1'b1;
        s_addr_o  = addr_q;
        s_we_o    = we_q;
        s_wdata_o = wdata_q;
      end
      ARB_RESP: begin
        m_gnt_o    = owner_onehot;
        m_rvalid_o = owner_onehot;
        m_rdata_o  = rdata_q;
        m_err_o    = err_q;
      end
      default: ;
    endcase
  end

  // Pending non-IFU requests stall the pipeline even before they are granted;
  // reset forces the hold low so the pipeline is released immediately.
  assign hold_flag_o = !rst &&
                       (((state_q != ARB_IDLE) && (owner_q != OW'(NUM_M - 1))) ||
                        (|m_req_i[NUM_M-2:0]));

endmodule

// File: tb/tb_rib_arb.sv
// Directed self-checking bench for rib_arb with a response scoreboard.
// The bench plays the slave, so it knows each expected read/err up front.
module tb_rib_arb;
  import rib_arb_pkg::*;

  localparam int NUM_M = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic                clk;
  logic                rst;
  logic [NUM_M-1:0]    m_req_i;
  logic [NUM_M*AW-1:0] m_addr_i;
  logic [NUM_M-1:0]    m_we_i;
  logic [NUM_M*DW-1:0] m_wdata_i;
  logic [NUM_M-1:0]    m_gnt_o;
  logic [NUM_M-1:0]    m_rvalid_o;
  logic [DW-1:0]       m_rdata_o;
  logic                m_err_o;
  logic                s_req_o;
  logic [AW-1:0]       s_addr_o;
  logic                s_we_o;
  logic [DW-1:0]       s_wdata_o;
  logic [DW-1:0]       s_rdata_i;
  logic                s_ack_i;
  logic                hold_flag_o;

  typedef struct packed {
    logic [NUM_M-1:0] mask;
    logic [DW-1:0]    rdata;
    logic             err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  rib_arb #(
    .NUM_M   (NUM_M),
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_req_i     (m_req_i),
    .m_addr_i    (m_addr_i),
    .m_we_i      (m_we_i),
    .m_wdata_i   (m_wdata_i),
    .m_gnt_o     (m_gnt_o),
    .m_rvalid_o  (m_rvalid_o),
    .m_rdata_o   (m_rdata_o),
    .m_err_o     (m_err_o),
    .s_req_o     (s_req_o),
    .s_addr_o    (s_addr_o),
    .s_we_o      (s_we_o),
    .s_wdata_o   (s_wdata_o),
    .s_rdata_i   (s_rdata_i),
    .s_ack_i     (s_ack_i),
    .hold_flag_o (hold_flag_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic [AW-1:0] addr, input logic we,
                               input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                               input logic exp_err);
    exp_t e;
    m_req_i[idx]             = 1'b1;
    m_addr_i[idx*AW +: AW]   = addr;
    m_we_i[idx]              = we;
    m_wdata_i[idx*DW +: DW]  = wdata;
    e.mask                   = '0;
    e.mask[idx]              = 1'b1;
    e.rdata                  = exp_rdata;
    e.err                    = exp_err;
    sb.push_back(e);
  endtask

  task automatic dropReq(input int idx);
    m_req_i[idx] = 1'b0;
  endtask

  task automatic checkResp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s_sb_empty observed=rvalid 0x%0h expected=queued response", tag, m_rvalid_o);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_rvalid"}, 64'(m_rvalid_o), 64'(e.mask));
      checkOutput({tag, "_rdata"},  64'(m_rdata_o),  64'(e.rdata));
      checkOutput({tag, "_err"},    64'(m_err_o),    64'(e.err));
    end
  endtask

  task automatic runUntilRvalid(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (m_rvalid_o != '0) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $error("[TB] FAIL %s_wait observed=no rvalid within %0d cycles expected=rvalid", tag, budget);
    end
  endtask

  initial begin
    rst       = 1'b1;
    m_req_i   = '0;
    m_addr_i  = '0;
    m_we_i    = '0;
    m_wdata_i = '0;
    s_rdata_i = '0;
    s_ack_i   = 1'b0;
    #1;
    checkOutput("rst_sreq",   64'(s_req_o),     64'd0);
    checkOutput("rst_gnt",    64'(m_gnt_o),     64'd0);
    checkOutput("rst_rvalid", 64'(m_rvalid_o),  64'd0);
    checkOutput("rst_hold",   64'(hold_flag_o), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;

    $display("[TB] IFU read with ack on the third ACTIVE cycle");
    applyStimulus(M_IFU, 32'h0000_0100, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
    #1;
    checkOutput("ifu_c0_hold", 64'(hold_flag_o), 64'd0);
    tick();
    checkOutput("ifu_c1_sreq", 64'(s_req_o),     64'd1);
    checkOutput("ifu_c1_gnt",  64'(m_gnt_o),     64'h8);
    checkOutput("ifu_c1_addr", 64'(s_addr_o),    64'h100);
    checkOutput("ifu_c1_hold", 64'(hold_flag_o), 64'd0);
    tick();
    checkOutput("ifu_c2_sreq", 64'(s_req_o), 64'd1);
    tick();
    checkOutput("ifu_c3_sreq", 64'(s_req_o), 64'd1);
    s_ack_i   = 1'b1;
    s_rdata_i = 32'hDEAD_BEEF;
    tick();
    s_ack_i = 1'b0;
    checkResp("ifu_c4");
    checkOutput("ifu_c4_sreq", 64'(s_req_o),     64'd0);
    checkOutput("ifu_c4_hold", 64'(hold_flag_o), 64'd0);
    dropReq(M_IFU);
    tick();
    checkOutput("ifu_c5_rvalid", 64'(m_rvalid_o), 64'd0);
    checkOutput("ifu_c5_gnt",    64'(m_gnt_o),    64'd0);

    $display("[TB] EXU write and IFU read requested together");
    applyStimulus(M_EXU, 32'h1000_0004, 1'b1, 32'h55AA_55AA, 32'h1234_5678, 1'b0);
    applyStimulus(M_IFU, 32'h0000_0200, 1'b0, 32'h0,         32'hCAFE_F00D, 1'b0);
    #1;
    checkOutput("pair_c0_hold", 64'(hold_flag_o), 64'd1);
    tick();
    checkOutput("exu_c1_gnt",   64'(m_gnt_o),   64'h2);
    checkOutput("exu_c1_addr",  64'(s_addr_o),  64'h1000_0004);
    checkOutput("exu_c1_we",    64'(s_we_o),    64'd1);
    checkOutput("exu_c1_wdata", 64'(s_wdata_o), 64'h55AA_55AA);
    m_wdata_i[M_EXU*DW +: DW] = 32'h0000_0000;
    m_addr_i[M_EXU*AW +: AW]  = 32'hFFFF_FFF0;
    #1;
    checkOutput("exu_c1_wdata_stable", 64'(s_wdata_o), 64'h55AA_55AA);
    checkOutput("exu_c1_addr_stable",  64'(s_addr_o),  64'h1000_0004);
    tick();
    checkOutput("exu_c2_wdata", 64'(s_wdata_o), 64'h55AA_55AA);
    s_ack_i   = 1'b1;
    s_rdata_i = 32'h1234_5678;
    tick();
    s_ack_i = 1'b0;
    checkResp("exu_c3");
    checkOutput("exu_c3_gnt", 64'(m_gnt_o), 64'h2);
    dropReq(M_EXU);
    #1;
    checkOutput("exu_c3_hold", 64'(hold_flag_o), 64'd1);
    tick();
    checkOutput("pair_c4_gnt",  64'(m_gnt_o),     64'd0);
    checkOutput("pair_c4_hold", 64'(hold_flag_o), 64'd0);
    tick();
    checkOutput("ifu2_c5_gnt",  64'(m_gnt_o),  64'h8);
    checkOutput("ifu2_c5_addr", 64'(s_addr_o), 64'h200);
    checkOutput("ifu2_c5_we",   64'(s_we_o),   64'd0);
    s_ack_i   = 1'b1;
    s_rdata_i = 32'hCAFE_F00D;
    runUntilRvalid("ifu2", 8);
    s_ack_i = 1'b0;
    checkResp("ifu2");
    dropReq(M_IFU);
    tick();

    $display("[TB] stray ack while idle");
    s_ack_i   = 1'b1;
    s_rdata_i = 32'h1111_1111;
    tick();
    checkOutput("idle_ack_sreq",   64'(s_req_o),    64'd0);
    checkOutput("idle_ack_rvalid", 64'(m_rvalid_o), 64'd0);
    s_ack_i = 1'b0;
    tick();
    checkOutput("idle_ack_rvalid2", 64'(m_rvalid_o), 64'd0);

    $display("[TB] CLINT access with no slave ack");
    applyStimulus(M_CLINT, 32'h2000_0000, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int c = 1; c <= 4; c++) begin
      tick();
      checkOutput($sformatf("to_c%0d_sreq", c), 64'(s_req_o), 64'd1);
    end
    tick();
    checkResp("to_c5");
    checkOutput("to_c5_sreq", 64'(s_req_o), 64'd0);
    dropReq(M_CLINT);
    tick();
    checkOutput("to_c6_gnt",  64'(m_gnt_o), 64'd0);
    checkOutput("to_c6_sreq", 64'(s_req_o), 64'd0);

    $display("[TB] JTAG ack coincident with the timeout cycle");
    applyStimulus(M_JTAG, 32'h3000_0008, 1'b0, 32'h0, 32'hA5A5_0001, 1'b0);
    tick();
    tick();
    tick();
    tick();
    checkOutput("tie_c4_sreq", 64'(s_req_o), 64'd1);
    s_ack_i   = 1'b1;
    s_rdata_i = 32'hA5A5_0001;
    tick();
    s_ack_i = 1'b0;
    checkResp("tie_c5");
    dropReq(M_JTAG);
    tick();

    $display("[TB] reset asserted during an EXU transaction");
    applyStimulus(M_EXU, 32'h1000_0010, 1'b0, 32'h0, 32'h0BAD_F00D, 1'b0);
    tick();
    checkOutput("rstm_c1_sreq", 64'(s_req_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstm_sreq", 64'(s_req_o),     64'd0);
    checkOutput("rstm_gnt",  64'(m_gnt_o),     64'd0);
    checkOutput("rstm_hold", 64'(hold_flag_o), 64'd0);
    void'(sb.pop_back());
    tick();
    checkOutput("rstm_rvalid", 64'(m_rvalid_o), 64'd0);
    rst = 1'b0;
    sb.push_back('{mask: 4'b0010, rdata: 32'h0BAD_F00D, err: 1'b0});
    tick();
    checkOutput("rstm_resume_gnt",  64'(m_gnt_o),  64'h2);
    checkOutput("rstm_resume_addr", 64'(s_addr_o), 64'h1000_0010);
    s_ack_i   = 1'b1;
    s_rdata_i = 32'h0BAD_F00D;
    runUntilRvalid("rstm", 8);
    s_ack_i = 1'b0;
    checkResp("rstm");
    dropReq(M_EXU);
    tick();
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
